div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Issue and writeback controller that sits directly upstream and downstream of the iterative 32-bit divider in the execute stage.
- Accepts RV32M DIV/DIVU/REM/REMU requests from decode/execute, decides whether the divider must run, launches it, and waits for completion.
- Selects quotient or remainder and presents a single-cycle writeback to the register file.
- Resolves RISC-V divide-by-zero and signed-overflow cases locally without starting the divider, and stalls the pipeline while a division is outstanding.

Parameters:
- DW, 32, operand/result width.
- RW, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  divide request present
- req_op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_rs1_i  in  DW  dividend
- req_rs2_i  in  DW  divisor
- req_rd_i  in  RW  destination register
- req_ready_o  out  1  request accepted this cycle when high with req_valid_i
- flush_i  in  1  kill in-flight operation
- stall_o  out  1  hold upstream pipeline
- div_start_o  out  1  start pulse to divider
- div_dividend_o  out  DW  divider dividend
- div_divisor_o  out  DW  divider divisor
- div_signed_o  out  1  divider signed mode
- div_busy_i  in  1  divider busy
- div_done_i  in  1  divider result valid (level)
- div_quot_i  in  DW  divider quotient
- div_rem_i  in  DW  divider remainder
- wb_valid_o  out  1  writeback strobe
- wb_rd_o  out  RW  writeback register
- wb_data_o  out  DW  writeback data

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP, DRAIN. Registered state and data.
- Reset: state=IDLE. All registered outputs 0: div_start_o, div_dividend_o, div_divisor_o, div_signed_o, wb_valid_o, wb_rd_o, wb_data_o. stall_o=0. req_ready_o is combinational (state==IDLE), so it reads 1 during and after reset.
- IDLE: accept when req_valid_i && !flush_i. Latch op, rd, rs1, rs2. div_signed_o = ~req_op_i[0].
  - req_valid_i with flush_i in the same cycle: request dropped, stay IDLE.
- Fast path, decided at accept:
  - divisor==0: quotient = all ones, remainder = rs1. Go to RESP.
  - Signed op with rs1==0x8000_0000 and rs2==0xFFFF_FFFF: quotient = 0x8000_0000, remainder = 0. Go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: if !div_busy_i, pulse div_start_o for exactly 1 cycle and go to WAIT; else hold in ISSUE. Divider operand outputs stay stable from accept until leaving WAIT/DRAIN.
- WAIT: on the first cycle div_done_i=1, capture div_quot_i/div_rem_i and go to RESP.
- RESP: wb_valid_o=1 for exactly one cycle. wb_data_o = quotient for op[1]=0, remainder for op[1]=1. wb_rd_o = latched rd. Next state IDLE.
- stall_o = 1 in ISSUE, WAIT and DRAIN; 0 in IDLE and RESP.
- Latency, accept at cycle T:
  - Fast path: wb_valid_o at T+1.
  - Normal path: div_start_o at T+1 (if divider idle); wb_valid_o one cycle after div_done_i is first seen.
- No new request is accepted in RESP; back-to-back requests are accepted at the earliest in the cycle after RESP.
- Flush:
  - In ISSUE before start issued: go to IDLE.
  - In ISSUE on the start cycle, or in WAIT: go to DRAIN. The divider has no abort, so wait for div_done_i, discard the result, then go to IDLE. No writeback.
  - In RESP: wb_valid_o forced 0.
- div_done_i outside WAIT/DRAIN is ignored.
- Reset mid-operation: immediate return to IDLE, outputs cleared, no writeback.

Test Plan:
- DIV rs1=0xFFFF_FFF9 (-7), rs2=2 -> one div_start_o pulse with div_signed_o=1. Model divider returns quot=0xFFFF_FFFD, rem=0xFFFF_FFFF. Required: wb_valid_o one cycle after done, wb_data_o=0xFFFF_FFFD, wb_rd_o=latched rd.
- REMU rs1=100, rs2=7 -> div_signed_o=0, wb_data_o=2. stall_o high from ISSUE until RESP.
- DIVU rs2=0, rs1=5 -> no div_start_o. wb_valid_o at T+1 with data 0xFFFF_FFFF. Same operands with REM -> data 5.
- DIV rs1=0x8000_0000, rs2=0xFFFF_FFFF -> no start, data 0x8000_0000. REM with the same operands -> data 0.
- flush_i asserted in WAIT -> stall_o held until div_done_i, then IDLE. wb_valid_o never asserted. Next request completes correctly.
- rst pulsed during WAIT -> all outputs 0, req_ready_o=1. Late div_done_i produces no writeback.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//
// Issue and writeback controller around the iterative RV32M divider in the
// execute stage. A DIV/DIVU/REM/REMU request is accepted in IDLE. If the
// result is architecturally fixed (divide by zero, or signed overflow
// 0x8000_0000 / -1), it is produced locally and written back on the next
// cycle. Otherwise the divider is launched with a one-cycle start pulse. The
// controller then waits for div_done_i and writes back either the quotient or
// the remainder. The upstream pipeline is stalled while a division is
// outstanding.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   req_valid_i         divide request present
//   req_op_i            00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_rs1_i/rs2_i     dividend / divisor
//   req_rd_i            destination register
//   req_ready_o         high in IDLE; request taken when req_valid_i is also high
//   flush_i             kill the in-flight operation (no writeback)
//   stall_o             hold upstream while ISSUE / WAIT / DRAIN
//   div_start_o         one-cycle launch pulse to the divider
//   div_dividend_o      divider dividend, stable for the whole operation
//   div_divisor_o       divider divisor, stable for the whole operation
//   div_signed_o        divider signed mode
//   div_busy_i          divider busy; launch is held off while high
//   div_done_i          divider result valid (level)
//   div_quot_i/rem_i    divider quotient / remainder
//   wb_valid_o          single-cycle writeback strobe
//   wb_rd_o, wb_data_o  writeback register and data
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  input  logic [1:0]    req_op_i,
  input  logic [DW-1:0] req_rs1_i,
  input  logic [DW-1:0] req_rs2_i,
  input  logic [RW-1:0] req_rd_i,
  output logic          req_ready_o,
  input  logic          flush_i,
  output logic          stall_o,
  output logic          div_start_o,
  output logic [DW-1:0] div_dividend_o,
  output logic [DW-1:0] div_divisor_o,
  output logic          div_signed_o,
  input  logic          div_busy_i,
  input  logic          div_done_i,
  input  logic [DW-1:0] div_quot_i,
  input  logic [DW-1:0] div_rem_i,
  output logic          wb_valid_o,
  output logic [RW-1:0] wb_rd_o,
  output logic [DW-1:0] wb_data_o
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } state_t;

  localparam logic signed [DW-1:0] SMIN  = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] SNEG1 = '1;

  // Signed overflow: most negative dividend divided by -1.
  function automatic logic is_ovf(input logic sgn,
                                  input logic signed [DW-1:0] a,
                                  input logic signed [DW-1:0] b);
    return sgn && (a == SMIN) && (b == SNEG1);
  endfunction

  // Architecturally fixed result for the two cases resolved without the divider.
  // Divide by zero: q = all ones, r = dividend. Overflow: q = SMIN, r = 0.
  function automatic logic [DW-1:0] fast_result(input logic rem_sel,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = SMIN;
      r = '0;
    end
    return rem_sel ? r : q;
  endfunction

  function automatic logic [DW-1:0] sel_result(input logic rem_sel,
                                               input logic [DW-1:0] q,
                                               input logic [DW-1:0] r);
    return rem_sel ? r : q;
  endfunction

  state_t        state;
  logic          rem_sel_q;
  logic [RW-1:0] rd_q;
  logic          wb_valid_q;
  logic          fast_hit;

  assign fast_hit = (req_rs2_i == '0) ||
                    is_ovf(~req_op_i[0], req_rs1_i, req_rs2_i);

  assign req_ready_o = (state == IDLE);
  assign stall_o     = (state == ISSUE) || (state == WAIT) || (state == DRAIN);
  // A flush landing in the response cycle still has to suppress the write.
  assign wb_valid_o  = wb_valid_q & ~flush_i;

  // Controller: accept, launch, wait, respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rem_sel_q      <= 1'b0;
      rd_q           <= '0;
      div_start_o    <= 1'b0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
      div_signed_o   <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
    end else begin
      div_start_o <= 1'b0;
      wb_valid_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i && !flush_i) begin
            rem_sel_q      <= req_op_i[1];
            rd_q           <= req_rd_i;
            div_dividend_o <= req_rs1_i;
            div_divisor_o  <= req_rs2_i;
            div_signed_o   <= ~req_op_i[0];
            if (fast_hit) begin
              wb_valid_q <= 1'b1;
              wb_rd_o    <= req_rd_i;
              wb_data_o  <= fast_result(req_op_i[1], req_rs1_i, req_rs2_i);
              state      <= RESP;
            end else begin
              // Launch straight away when the divider is free, so the start
              // pulse lands in the first ISSUE cycle.
              div_start_o <= ~div_busy_i;
              state       <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (div_start_o) begin
            // The divider has already seen the start; it cannot be aborted.
            state <= flush_i ? DRAIN : WAIT;
          end else if (flush_i) begin
            state <= IDLE;
          end else if (!div_busy_i) begin
            div_start_o <= 1'b1;
          end
        end

        WAIT: begin
          if (div_done_i) begin
            if (flush_i) begin
              state <= IDLE;
            end else begin
              wb_valid_q <= 1'b1;
              wb_rd_o    <= rd_q;
              wb_data_o  <= sel_result(rem_sel_q, div_quot_i, div_rem_i);
              state      <= RESP;
            end
          end else if (flush_i) begin
            state <= DRAIN;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        DRAIN: begin
          // Result of a killed division is discarded.
          if (div_done_i) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_i;
  logic [1:0]    req_op_i;
  logic [DW-1:0] req_rs1_i;
  logic [DW-1:0] req_rs2_i;
  logic [RW-1:0] req_rd_i;
  logic          req_ready_o;
  logic          flush_i;
  logic          stall_o;
  logic          div_start_o;
  logic [DW-1:0] div_dividend_o;
  logic [DW-1:0] div_divisor_o;
  logic          div_signed_o;
  logic          div_busy_i;
  logic          div_done_i;
  logic [DW-1:0] div_quot_i;
  logic [DW-1:0] div_rem_i;
  logic          wb_valid_o;
  logic [RW-1:0] wb_rd_o;
  logic [DW-1:0] wb_data_o;

  div_issue_ctrl #(.DW(DW), .RW(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_op_i       (req_op_i),
    .req_rs1_i      (req_rs1_i),
    .req_rs2_i      (req_rs2_i),
    .req_rd_i       (req_rd_i),
    .req_ready_o    (req_ready_o),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .div_start_o    (div_start_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_signed_o   (div_signed_o),
    .div_busy_i     (div_busy_i),
    .div_done_i     (div_done_i),
    .div_quot_i     (div_quot_i),
    .div_rem_i      (div_rem_i),
    .wb_valid_o     (wb_valid_o),
    .wb_rd_o        (wb_rd_o),
    .wb_data_o      (wb_data_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wb_cnt   = 0;
  int start_cnt = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference RV32M division result, including the fixed corner cases.
  function automatic logic [DW-1:0] ref_div(input logic [1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Behavioural iterative divider: busy for dv_lat+1 cycles after start,
  // then done for one cycle. Results read garbage until done.
  logic          dv_busy = 1'b0;
  logic          dv_done = 1'b0;
  logic          inj_busy = 1'b0;
  int            dv_cnt = 0;
  int            dv_lat = 3;
  logic [DW-1:0] dv_q = '0, dv_r = '0, dv_pq = '0, dv_pr = '0;

  assign div_busy_i = dv_busy | inj_busy;
  assign div_done_i = dv_done;
  assign div_quot_i = dv_q;
  assign div_rem_i  = dv_r;

  always @(posedge clk) begin
    if (div_start_o === 1'b1) begin
      start_cnt <= start_cnt + 1;
      dv_pq   <= ref_div({1'b0, ~div_signed_o}, div_dividend_o, div_divisor_o);
      dv_pr   <= ref_div({1'b1, ~div_signed_o}, div_dividend_o, div_divisor_o);
      dv_q    <= 32'hDEAD_BEEF;
      dv_r    <= 32'hBAD0_BAD0;
      dv_busy <= 1'b1;
      dv_cnt  <= dv_lat;
      dv_done <= 1'b0;
    end else if (dv_busy) begin
      if (dv_cnt == 0) begin
        dv_busy <= 1'b0;
        dv_done <= 1'b1;
        dv_q    <= dv_pq;
        dv_r    <= dv_pr;
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end else begin
      dv_done <= 1'b0;
    end
  end

  // Scoreboard: every writeback must match the oldest expected entry.
  always @(negedge clk) begin
    if (wb_valid_o === 1'b1) begin
      wb_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", wb_rd_o, wb_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (wb_rd_o !== e.rd || wb_data_o !== e.data) begin
          n_fail++;
          $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h", wb_rd_o, wb_data_o, e.rd, e.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [RW-1:0] rd, input bit push);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (req_ready_o !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_ready_timeout: req_ready_o=%b, required 1 within 100 cycles", req_ready_o);
    end
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_rs1_i   = a;
    req_rs2_i   = b;
    req_rd_i    = rd;
    if (push) begin
      e.rd   = rd;
      e.data = ref_div(op, a, b);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_wb(input int target, input string name);
    int guard;
    guard = 0;
    while (wb_cnt < target && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (wb_cnt < target) begin
      n_fail++;
      $display("FAIL %s_wb_timeout: writebacks=%0d, required %0d", name, wb_cnt, target);
    end
  endtask

  task automatic wait_done(output bit ok);
    int guard;
    guard = 0;
    ok = 1'b0;
    while (guard < 200) begin
      @(negedge clk);
      if (div_done_i === 1'b1) begin
        ok = 1'b1;
        break;
      end
      guard++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: div_done_i never seen, required within 200 cycles");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    n_checks++;
    if ({div_start_o, div_signed_o, wb_valid_o, stall_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: start/signed/wb_valid/stall=%b, required 0000",
               {div_start_o, div_signed_o, wb_valid_o, stall_o});
    end
    n_checks++;
    if ({div_dividend_o, div_divisor_o, wb_rd_o, wb_data_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: dividend=%h divisor=%h rd=%0d data=%h, required all 0",
               div_dividend_o, div_divisor_o, wb_rd_o, wb_data_o);
    end
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: req_ready_o=%b, required 1", req_ready_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if ({req_ready_o, stall_o, wb_valid_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL post_reset: ready/stall/wb_valid=%b, required 100", {req_ready_o, stall_o, wb_valid_o});
    end
  endtask

  task automatic test_div_signed;
    int s0;
    int w0;
    bit ok;
    s0 = start_cnt;
    w0 = wb_cnt;
    send(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1);
    n_checks++;
    if ({div_start_o, div_signed_o, stall_o} !== 3'b111) begin
      n_fail++;
      $display("FAIL div_start: start/signed/stall=%b, required 111", {div_start_o, div_signed_o, stall_o});
    end
    n_checks++;
    if (div_dividend_o !== 32'hFFFF_FFF9 || div_divisor_o !== 32'd2) begin
      n_fail++;
      $display("FAIL div_operands: dividend=%h divisor=%h, required fffffff9 00000002",
               div_dividend_o, div_divisor_o);
    end
    tick();
    n_checks++;
    if (div_start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL div_start_pulse: div_start_o=%b on second cycle, required 0", div_start_o);
    end
    wait_done(ok);
    if (ok) begin
      tick();
      n_checks++;
      if ({wb_valid_o, stall_o} !== 2'b10) begin
        n_fail++;
        $display("FAIL div_wb_latency: wb_valid/stall=%b one cycle after done, required 10", {wb_valid_o, stall_o});
      end
    end
    wait_wb(w0 + 1, "div_signed");
    n_checks++;
    if (start_cnt !== s0 + 1) begin
      n_fail++;
      $display("FAIL div_start_count: starts=%0d, required %0d", start_cnt - s0, 1);
    end
  endtask

  task automatic test_remu;
    int w0;
    bit ok;
    bit stall_bad;
    w0 = wb_cnt;
    stall_bad = 1'b0;
    send(2'b11, 32'd100, 32'd7, 5'd9, 1'b1);
    n_checks++;
    if ({div_start_o, div_signed_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL remu_start: start/signed=%b, required 10", {div_start_o, div_signed_o});
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stall_o !== 1'b1) stall_bad = 1'b1;
      if (div_done_i === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (stall_bad || !ok) begin
      n_fail++;
      $display("FAIL remu_stall: stall dropped=%b done seen=%b, required stall held and done seen", stall_bad, ok);
    end
    tick();
    n_checks++;
    if ({wb_valid_o, stall_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL remu_resp: wb_valid/stall=%b, required 10", {wb_valid_o, stall_o});
    end
    wait_wb(w0 + 1, "remu");
  endtask

  task automatic test_fast_path;
    logic [1:0]    ops[4] = '{2'b01, 2'b10, 2'b00, 2'b10};
    logic [DW-1:0] as[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [DW-1:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      int s0;
      int w0;
      s0 = start_cnt;
      w0 = wb_cnt;
      send(ops[i], as[i], bs[i], 5'(10 + i), 1'b1);
      n_checks++;
      if ({wb_valid_o, stall_o, req_ready_o, div_start_o} !== 4'b1000) begin
        n_fail++;
        $display("FAIL fast_%0d_timing: wb_valid/stall/ready/start=%b at T+1, required 1000",
                 i, {wb_valid_o, stall_o, req_ready_o, div_start_o});
      end
      wait_wb(w0 + 1, "fast");
      tick();
      n_checks++;
      if (start_cnt !== s0) begin
        n_fail++;
        $display("FAIL fast_%0d_nostart: starts=%0d, required 0", i, start_cnt - s0);
      end
    end
  endtask

  task automatic test_near_overflow;
    int s0;
    int w0;
    s0 = start_cnt;
    w0 = wb_cnt;
    send(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1);
    send(2'b10, 32'h8000_0000, 32'd1, 5'd15, 1'b1);
    wait_wb(w0 + 2, "near_ovf");
    n_checks++;
    if (start_cnt !== s0 + 2) begin
      n_fail++;
      $display("FAIL near_ovf_starts: starts=%0d, required 2", start_cnt - s0);
    end
  endtask

  task automatic test_back_to_back;
    int c0;
    int w0;
    w0 = wb_cnt;
    send(2'b00, 32'd7, 32'd0, 5'd16, 1'b1);
    c0 = cyc;
    send(2'b11, 32'd9, 32'd0, 5'd17, 1'b1);
    n_checks++;
    if (cyc - c0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_accept_gap: accepted %0d cycles apart, required 2", cyc - c0);
    end
    wait_wb(w0 + 2, "b2b");
  endtask

  task automatic test_busy_release;
    int w0;
    w0 = wb_cnt;
    inj_busy = 1'b1;
    send(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1);
    tick();
    tick();
    n_checks++;
    if ({stall_o, div_start_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL busy_hold: stall/start=%b while divider busy, required 10", {stall_o, div_start_o});
    end
    @(negedge clk);
    inj_busy = 1'b0;
    tick();
    n_checks++;
    if (div_start_o !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_release_start: div_start_o=%b, required 1", div_start_o);
    end
    wait_wb(w0 + 1, "busy_release");
  endtask

  task automatic test_flush_issue;
    int s0;
    s0 = start_cnt;
    inj_busy = 1'b1;
    send(2'b00, 32'd9, 32'd3, 5'd2, 1'b0);
    tick();
    @(negedge clk);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_checks++;
    if ({req_ready_o, stall_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_issue_idle: ready/stall=%b, required 10", {req_ready_o, stall_o});
    end
    inj_busy = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (start_cnt !== s0) begin
      n_fail++;
      $display("FAIL flush_issue_nostart: starts=%0d, required 0", start_cnt - s0);
    end
  endtask

  task automatic test_flush_resp;
    int w0;
    w0 = wb_cnt;
    send(2'b01, 32'd5, 32'd0, 5'd1, 1'b0);
    flush_i = 1'b1;
    #1;
    n_checks++;
    if (wb_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_resp: wb_valid_o=%b with flush in RESP, required 0", wb_valid_o);
    end
    tick();
    flush_i = 1'b0;
    tick();
    n_checks++;
    if (wb_cnt !== w0) begin
      n_fail++;
      $display("FAIL flush_resp_count: writebacks=%0d, required 0", wb_cnt - w0);
    end
  endtask

  task automatic test_drop_flush_idle;
    int s0;
    int w0;
    s0 = start_cnt;
    w0 = wb_cnt;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = 2'b00;
    req_rs1_i   = 32'd10;
    req_rs2_i   = 32'd2;
    req_rd_i    = 5'd3;
    flush_i     = 1'b1;
    tick();
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    n_checks++;
    if ({req_ready_o, stall_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL drop_idle_state: ready/stall=%b, required 10", {req_ready_o, stall_o});
    end
    repeat (3) tick();
    n_checks++;
    if (start_cnt !== s0 || wb_cnt !== w0) begin
      n_fail++;
      $display("FAIL drop_idle_effect: starts=%0d writebacks=%0d, required 0 0", start_cnt - s0, wb_cnt - w0);
    end
  endtask

  task automatic test_flush_wait;
    int w0;
    bit ok;
    bit stall_bad;
    w0 = wb_cnt;
    stall_bad = 1'b0;
    dv_lat = 6;
    send(2'b00, 32'd40, 32'd5, 5'd3, 1'b0);
    tick();
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (div_done_i === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (stall_o !== 1'b1) stall_bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (stall_bad || !ok) begin
      n_fail++;
      $display("FAIL flush_wait_stall: stall dropped=%b done seen=%b, required stall held and done seen", stall_bad, ok);
    end
    tick();
    n_checks++;
    if ({req_ready_o, stall_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_wait_idle: ready/stall=%b after done, required 10", {req_ready_o, stall_o});
    end
    tick();
    n_checks++;
    if (wb_cnt !== w0) begin
      n_fail++;
      $display("FAIL flush_wait_nowb: writebacks=%0d, required 0", wb_cnt - w0);
    end
    dv_lat = 3;
    send(2'b00, 32'd40, 32'd5, 5'd4, 1'b1);
    wait_wb(w0 + 1, "after_flush");
  endtask

  task automatic test_reset_mid;
    int w0;
    bit ok;
    w0 = wb_cnt;
    dv_lat = 6;
    send(2'b00, 32'd50, 32'd7, 5'd6, 1'b0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({div_start_o, div_signed_o, wb_valid_o, stall_o, req_ready_o} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_mid_ctrl: start/signed/wb_valid/stall/ready=%b, required 00001",
               {div_start_o, div_signed_o, wb_valid_o, stall_o, req_ready_o});
    end
    n_checks++;
    if ({div_dividend_o, div_divisor_o, wb_rd_o, wb_data_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_data: dividend=%h divisor=%h rd=%0d data=%h, required all 0",
               div_dividend_o, div_divisor_o, wb_rd_o, wb_data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_done(ok);
    repeat (3) tick();
    n_checks++;
    if (wb_cnt !== w0 || req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_late_done: writebacks=%0d ready=%b, required 0 1", wb_cnt - w0, req_ready_o);
    end
    dv_lat = 3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid_i = 1'b0;
    req_op_i    = 2'b00;
    req_rs1_i   = '0;
    req_rs2_i   = '0;
    req_rd_i    = '0;
    flush_i     = 1'b0;
    rst         = 1'b1;

    test_reset();
    test_div_signed();
    test_remu();
    test_fast_path();
    test_near_overflow();
    test_back_to_back();
    test_busy_release();
    test_flush_issue();
    test_flush_resp();
    test_drop_flush_idle();
    test_flush_wait();
    test_reset_mid();

    repeat (2) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected writebacks outstanding, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
